// File: rtl/seg_scan.sv
// Multiplexed hex display driver for common-anode 7-segment banks.
// Scans NUM_DIGITS digits with frame snapshots, leading-zero suppression, brightness and a guard cycle.
module seg_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [3:0]              bright,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   SLICE   = (CNT_W + 1)'(SCAN_DIV / 16);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;

  logic       cnt_wrap, last_digit, frame_end;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_blank, lead_zero, dark, window;
  logic [CNT_W:0] win_limit;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Prescaler, digit index and frame-boundary snapshot.
  always_comb begin
    cnt_wrap   = (cnt_q == CNT_MAX);
    last_digit = (idx_q == IDX_MAX);
    frame_end  = cnt_wrap && last_digit;

    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_wrap) idx_d = last_digit ? '0 : idx_q + IDX_W'(1);

    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_lz_d    = sh_lz_q;
    if (frame_end) begin
      sh_data_d  = data;
      sh_dp_d    = dp_in;
      sh_blank_d = blank;
      sh_lz_d    = lz_en;
    end
    fs_d = frame_end;
  end

  // Per-digit output image for the current (cnt, idx), registered next edge.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is
    // inferred; blocking '=' is correct here because later lines read the updated values.
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    lead_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) <= idx_q && sh_data_q[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) lead_zero = 1'b0;
      if (IDX_W'(k) == idx_q) begin
        cur_nib   = sh_data_q[4*(NUM_DIGITS-1-k) +: 4];
        cur_dp    = sh_dp_q[NUM_DIGITS-1-k];
        cur_blank = sh_blank_q[NUM_DIGITS-1-k];
      end
    end
    dark = cur_blank || (sh_lz_q && lead_zero && !last_digit);

    // cnt==0 stays dark as the anti-ghost guard between digits.
    win_limit = ((CNT_W + 1)'(bright) + (CNT_W + 1)'(1)) * SLICE;
    window    = (cnt_q != '0) && ({1'b0, cnt_q} < win_limit);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_d[NUM_DIGITS-1-k] = !(window && IDX_W'(k) == idx_q);
    end

    seg_d = dark ? 7'h7F : hex_glyph(cur_nib);
    dp_d  = dark ? 1'b1 : !cur_dp;
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  // The shadow registers are reset too, so the first frame shows defined zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      sh_lz_q    <= 1'b0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_lz_q    <= sh_lz_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: time-based behavioural model compared every cycle,
// plus hand-computed glyph/anode/latency expectations and randomized stimulus.
module tb_seg_scan;
  localparam int N  = 8;
  localparam int S  = 64;
  localparam int NS = N * S;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] data;
  logic [N-1:0]  dp_in, blank;
  logic          lz_en;
  logic [3:0]    bright;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  int errors = 0;
  int checks = 0;

  seg_scan #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .blank(blank),
    .lz_en(lz_en), .bright(bright), .an(an), .seg(seg), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int            t_m;          // cycles since frame start: digit = t/S, cnt = t%S
  logic [4*N-1:0] sh_data;
  logic [N-1:0]  sh_dp, sh_blank;
  logic          sh_lz;
  logic [N-1:0]  exp_an;
  logic [6:0]    exp_seg;
  logic          exp_dp, exp_fs;

  function automatic logic m_dark(input int k);
    logic [4*N-1:0] upper;
    upper = sh_data >> (4 * (N - 1 - k));
    return sh_blank[N-1-k] || (sh_lz && k != N - 1 && upper == '0);
  endfunction

  function automatic logic [N-1:0] m_an(input int t, input logic [3:0] b);
    int c, k, lim;
    logic [N-1:0] one;
    c = t % S;
    k = t / S;
    lim = (int'(b) + 1) * (S / 16);
    one = 1;
    if (c != 0 && c < lim) return ~(one << (N - 1 - k));
    return '1;
  endfunction

  function automatic logic [6:0] m_seg(input int t);
    int k;
    logic [4*N-1:0] sh;
    k = t / S;
    sh = sh_data >> (4 * (N - 1 - k));
    if (m_dark(k)) return 7'h7F;
    return glyph[sh[3:0]];
  endfunction

  function automatic logic m_dp(input int t);
    int k;
    k = t / S;
    if (m_dark(k)) return 1'b1;
    return ~sh_dp[N-1-k];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_m <= 0; sh_data <= '0; sh_dp <= '0; sh_blank <= '0; sh_lz <= 1'b0;
      exp_an <= '1; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fs <= 1'b0;
    end else begin
      exp_an  <= m_an(t_m, bright);
      exp_seg <= m_seg(t_m);
      exp_dp  <= m_dp(t_m);
      exp_fs  <= (t_m == NS - 1);
      if (t_m == NS - 1) begin
        sh_data <= data; sh_dp <= dp_in; sh_blank <= blank; sh_lz <= lz_en;
      end
      t_m <= (t_m + 1) % NS;
    end
  end

  // Cycle-by-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    check("an",          32'(an),          32'(exp_an));
    check("seg",         32'(seg),         32'(exp_seg));
    check("dp",          32'(dp),          32'(exp_dp));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2 * NS);
    check("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  // Return at the falling edge where the outputs show digit k at cnt c.
  task automatic wait_out(input int k, input int c);
    int target, n;
    target = (k * S + c + 1) % NS;
    n = 0;
    do begin @(negedge clk); n++; end while (t_m != target && n < 2 * NS);
  endtask

  initial begin
    int n;
    bit found;
    data = $urandom; dp_in = 8'($urandom); blank = 8'($urandom);
    lz_en = 1'b1; bright = 4'($urandom);
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_an",  32'(an),          32'hFF);
    check("rst_seg", 32'(seg),         32'h7F);
    check("rst_dp",  32'(dp),          32'd1);
    check("rst_fs",  32'(frame_start), 32'd0);

    rst = 1'b1;
    n = 0; found = 1'b0;
    while (n < 2 * NS && !found) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (frame_start) found = 1'b1;
    end
    check("first_fs_latency", 32'(n), 32'(NS));

    // Decode sweep and snapshot behaviour.
    data = 32'h0123_4567; bright = 4'd15; lz_en = 1'b0; blank = '0; dp_in = '0;
    wait_frame();
    wait_out(2, 0); check("guard_an", 32'(an), 32'hFF);
    wait_out(2, 5); check("d2_seg", 32'(seg), 32'(7'b0100100)); check("d2_an", 32'(an), 32'hDF);
    data = 32'h89AB_CDEF;
    wait_out(5, 7); check("snap_hold_seg", 32'(seg), 32'(7'b0010010));
    wait_frame();
    wait_out(3, 9); check("d3_b_seg", 32'(seg), 32'(7'b0000011));
    data = 32'h1111_1111;
    repeat (10) @(negedge clk);
    data = 32'h89AB_CDEF;
    wait_frame();
    wait_out(0, 1); check("toggle_hidden_seg", 32'(seg), 32'(7'b0000000));

    // Leading-zero suppression.
    data = 32'h0000_00A0; lz_en = 1'b1;
    wait_frame();
    wait_out(5, 2); check("lz_d5_dark", 32'(seg), 32'h7F);
    wait_out(6, 2); check("lz_d6_A",    32'(seg), 32'(7'b0001000));
    wait_out(7, 2); check("lz_d7_0",    32'(seg), 32'(7'b1000000));
    data = 32'h0;
    wait_frame();
    wait_out(0, 2); check("lz0_d0_dark", 32'(seg), 32'h7F);
    wait_out(7, 2); check("lz0_d7_seg", 32'(seg), 32'(7'b1000000)); check("lz0_d7_an", 32'(an), 32'hFE);

    // Brightness windows (SLICE = 4).
    data = 32'h0123_4567; lz_en = 1'b0; bright = 4'd3;
    wait_frame();
    wait_out(0, 15); check("b3_on_15",  32'(an), 32'h7F);
    wait_out(0, 16); check("b3_off_16", 32'(an), 32'hFF);
    bright = 4'd0;
    wait_out(1, 3); check("b0_on_3",  32'(an), 32'hBF);
    wait_out(1, 4); check("b0_off_4", 32'(an), 32'hFF);
    bright = 4'd15;
    wait_out(1, 63); check("b15_on_63", 32'(an), 32'hBF);

    // Blanking and decimal points.
    blank = 8'h81; dp_in = 8'h10;
    wait_frame();
    wait_out(0, 5); check("blk_d0_seg", 32'(seg), 32'h7F); check("blk_d0_dp", 32'(dp), 32'd1);
    wait_out(3, 5); check("dp_d3", 32'(dp), 32'd0); check("dp_d3_seg", 32'(seg), 32'(7'b0110000));
    wait_out(4, 5); check("dp_d4", 32'(dp), 32'd1); check("d4_seg", 32'(seg), 32'(7'b0011001));
    wait_out(7, 5); check("blk_d7_seg", 32'(seg), 32'h7F);

    // Randomized run with a mid-frame reset; the model process checks every cycle.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        data  = $urandom >> (4 * $urandom_range(0, 8));
        dp_in = 8'($urandom);
        blank = 8'($urandom & $urandom & $urandom);
        lz_en = 1'($urandom_range(0, 1));
      end
      if (i == 3000) rst = 1'b0;
      if (i == 3003) rst = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised multiplexed hex display driver for common-anode 7-segment banks; it supersedes the fixed 8-digit scanner. It shows a packed nibble vector across `NUM_DIGITS` digits and adds:
- per-digit decimal points and blanking;
- leading-zero suppression;
- 16-level brightness;
- an anti-ghost guard cycle;
- tear-free frame snapshots.

It sits between the CPU debug/data bus and the board display pins, and contains its own hex-to-segment decoder.

## Interface
- `NUM_DIGITS`, 8, number of digits scanned; legal 1..16.
- `SCAN_DIV`, 65536, clock cycles per digit slot; must be ≥16 and a multiple of 16.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `data`  input  4*NUM_DIGITS  nibbles; `data[4*NUM_DIGITS-1 -: 4]` is digit 0 (leftmost), `data[3:0]` is digit NUM_DIGITS-1 (rightmost).
- `dp_in`  input  NUM_DIGITS  decimal point request; bit NUM_DIGITS-1-k belongs to digit k (MSB = leftmost).
- `blank`  input  NUM_DIGITS  force digit dark; same bit order as `dp_in`.
- `lz_en`  input  1  enable leading-zero suppression.
- `bright`  input  4  brightness level; 15 = full on.
- `an`  output  NUM_DIGITS  anode enables, active-low; bit NUM_DIGITS-1-k drives digit k.
- `seg`  output  7  segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  output  1  decimal point segment, active-low.
- `frame_start`  output  1  one-cycle pulse marking a snapshot load.

## Operation
- **Prescaler and digit index:**
  - `cnt` counts 0..SCAN_DIV-1 and wraps to 0.
  - `idx` advances by 1 when `cnt` wraps; after NUM_DIGITS-1 it wraps to 0.
  - With NUM_DIGITS=1, `idx` stays 0.
- **Snapshot:** `data`, `dp_in`, `blank` and `lz_en` are captured into shadow registers at the frame boundary. That is the edge where (`cnt`,`idx`) goes from (SCAN_DIV-1, NUM_DIGITS-1) to (0,0). Input changes between boundaries have no visible effect. `bright` is not snapshotted and applies live.
- **Leading-zero suppression** (shadow `lz_en`=1):
  - Digit k is suppressed if every shadow nibble from digit 0 through digit k equals 0.
  - The rightmost digit is never suppressed.
- **Digit visibility:** a digit is dark if its shadow `blank` bit is set or it is suppressed. A dark digit drives `seg`=7'h7F and `dp`=1; its anode pattern is still generated.
- **Decoder:** standard hex glyphs, active-low:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- **`dp`:** equals the inverse of the shadow `dp_in` bit of the current digit, when the digit is not dark.
- **Anode window:**
  - `SLICE` = SCAN_DIV/16.
  - `an` bit for `idx` is 0 only when `cnt` ≠ 0 and `cnt` < (bright+1)*SLICE; all other `an` bits are 1.
  - `cnt`==0 is the anti-ghost guard cycle: all anodes off.
  - bright=15 means on for cnt 1..SCAN_DIV-1.

## Timing
- `an`, `seg` and `dp` are registered from (`cnt`, `idx`, shadow, `bright`). Outputs lag the counters by exactly 1 cycle.
- `frame_start` is registered high for 1 cycle, on the same edge that loads the shadow registers.
- Digit 0 of the new frame first appears on the outputs 1 cycle after `frame_start` rises, and is dark because of the guard cycle. Anodes turn on 2 cycles after `frame_start` rises.
- **Reset (`rst`=0, asynchronous):**
  - `cnt`=0, `idx`=0.
  - Shadow registers all 0, so the first frame shows "0" digits, or only the rightmost "0" if the shadow `lz_en` is 1; shadow `lz_en` resets to 0.
  - `an`=all 1s, `seg`=7'h7F, `dp`=1, `frame_start`=0.
- **Reset mid-frame:** the scan aborts immediately and outputs go dark. After release, scanning restarts at digit 0 with `cnt`=0. The first `frame_start` occurs after NUM_DIGITS*SCAN_DIV cycles.
- **Input changes:** a `bright` change takes effect on the next cycle's output register update. A `bright` change and a frame boundary on the same edge are independent.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles with arbitrary inputs -> `an`=8'hFF, `seg`=7'h7F, `dp`=1, `frame_start`=0. Release -> the first `frame_start` pulse arrives exactly 8*SCAN_DIV cycles later (SCAN_DIV=16).
- **Decode sweep:** SCAN_DIV=16, data=32'h0123_4567, then 32'h89AB_CDEF, bright=15, lz_en=0 -> each slot shows the glyph table value. Anode patterns are 8'h7F, 8'hBF … 8'hFE for cnt 1..15, with all-ones during each guard cycle.
- **Leading zeros:** data=32'h0000_00A0, lz_en=1 -> digits 0-5 dark, digit 6 `seg`=0001000, digit 7 `seg`=1000000. data=0, lz_en=1 -> only digit 7 lit, showing "0".
- **Snapshot:** change `data` mid-frame -> the displayed value is unchanged until 1 cycle after the next `frame_start`; a value toggled and restored within a frame is never shown.
- **Brightness:** SCAN_DIV=64, bright=3 -> the active anode is low for cnt 1..15 (15 cycles/slot); bright=0 -> cnt 1..3; bright=15 -> cnt 1..63.
- **Mask and dp:** blank=8'h81, dp_in=8'h10 -> digits 0 and 7 `seg`=7'h7F, `dp`=1; digit 3 `dp`=0; the remaining digits show their glyph with `dp`=1.
